// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [3:0] MEM_SEL_ALL = 4'b1111;
endpackage

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: wrapping grant and conflict counters for the arbiter
module mem_arb_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant_i,
    input  logic             grant_d,
    input  logic             conflict,
    output logic [CNT_W-1:0] cnt_i_grant,
    output logic [CNT_W-1:0] cnt_d_grant,
    output logic [CNT_W-1:0] cnt_conflict
);
    // count each strobe, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_i_grant  <= '0;
            cnt_d_grant  <= '0;
            cnt_conflict <= '0;
        end else begin
            cnt_i_grant  <= cnt_i_grant + {{(CNT_W-1){1'b0}}, grant_i};
            cnt_d_grant  <= cnt_d_grant + {{(CNT_W-1){1'b0}}, grant_d};
            cnt_conflict <= cnt_conflict + {{(CNT_W-1){1'b0}}, conflict};
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between i_cache and d_cache
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_strobe,
    input  logic [31:0]      i_addr,
    output logic             i_ready,
    input  logic             d_strobe,
    input  logic [31:0]      d_addr,
    input  logic             d_write,
    input  logic [1:0]       d_size,
    input  logic [3:0]       d_sel,
    input  logic [31:0]      d_wdata,
    output logic             d_ready,
    output logic [31:0]      mem_a,
    output logic             mem_access,
    output logic             mem_write,
    output logic [1:0]       mem_size,
    output logic [3:0]       mem_sel,
    output logic [31:0]      mem_st_data,
    input  logic             mem_ready,
    input  logic [31:0]      mem_data,
    output logic [CNT_W-1:0] cnt_i_grant,
    output logic [CNT_W-1:0] cnt_d_grant,
    output logic [CNT_W-1:0] cnt_conflict
);
    state_t state, state_next;
    logic   last_d;
    logic   decide, i_req, d_req, grant_i, grant_d, conflict;
    logic   unused_data;

    assign unused_data = ^mem_data;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // grant decision and next state; the side being served is excluded on its ready cycle
    always_comb begin
        decide     = (state == IDLE) || mem_ready;
        i_req      = i_strobe && (state != BUSY_I);
        d_req      = d_strobe && (state != BUSY_D);
        grant_i    = decide && i_req && (!d_req || last_d);
        grant_d    = decide && d_req && (!i_req || !last_d);
        conflict   = decide && i_req && d_req;
        state_next = grant_i ? BUSY_I : grant_d ? BUSY_D : decide ? IDLE : state;
    end

    // outputs derived from the current state
    always_comb begin
        mem_access = state != IDLE;
        i_ready    = (state == BUSY_I) && mem_ready;
        d_ready    = (state == BUSY_D) && mem_ready;
    end

    // latch the winner's request so downstream sees stable values for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d      <= 1'b1;
            mem_a       <= '0;
            mem_write   <= 1'b0;
            mem_size    <= '0;
            mem_sel     <= '0;
            mem_st_data <= '0;
        end else if (grant_i) begin
            last_d      <= 1'b0;
            mem_a       <= i_addr;
            mem_write   <= 1'b0;
            mem_size    <= MEM_SIZE_WORD;
            mem_sel     <= MEM_SEL_ALL;
            mem_st_data <= '0;
        end else if (grant_d) begin
            last_d      <= 1'b1;
            mem_a       <= d_addr;
            mem_write   <= d_write;
            mem_size    <= d_size;
            mem_sel     <= d_sel;
            mem_st_data <= d_wdata;
        end
    end

    mem_arb_perf #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .rst          (rst),
        .grant_i      (grant_i),
        .grant_d      (grant_d),
        .conflict     (conflict),
        .cnt_i_grant  (cnt_i_grant),
        .cnt_d_grant  (cnt_d_grant),
        .cnt_conflict (cnt_conflict)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard-driven bench for the memory-port arbiter
module tb_mem_arbiter;
    typedef struct packed {
        logic        d;
        logic [31:0] a;
        logic        w;
        logic [1:0]  sz;
        logic [3:0]  sel;
        logic [31:0] wd;
    } txn_t;

    logic        clk = 0, rst = 1;
    logic        i_strobe = 0, d_strobe = 0, d_write = 0, mem_ready = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_data = 0;
    logic [1:0]  d_size = 0;
    logic [3:0]  d_sel = 0;
    logic        i_ready, d_ready, mem_access, mem_write;
    logic [31:0] mem_a, mem_st_data;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] cnt_i_grant, cnt_d_grant, cnt_conflict;

    int   n_checks = 0, n_fail = 0;
    txn_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_strobe(i_strobe), .i_addr(i_addr), .i_ready(i_ready),
        .d_strobe(d_strobe), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
        .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
        .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data),
        .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_conflict(cnt_conflict)
    );

    function automatic txn_t mk_i(input logic [31:0] a);
        return {1'b0, a, 1'b0, 2'b10, 4'hF, 32'h0};
    endfunction

    function automatic txn_t mk_d(input logic [31:0] a, input logic w, input logic [1:0] sz,
                                  input logic [3:0] sel, input logic [31:0] wd);
        return {1'b1, a, w, sz, sel, wd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; i_strobe = 0; d_strobe = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_write = 0; d_size = 0; d_sel = 0; d_wdata = 0;
        tick(); tick();
        rst = 0;
    endtask

    // called just after an edge; waits for a transaction, holds it, then pulses mem_ready
    task automatic serve(input int hold, output txn_t got, output logic ok);
        int k = 0;
        while (!mem_access && k < 20) begin tick(); k++; end
        repeat (hold) tick();
        mem_ready = 1;
        #4;
        got = {d_ready, mem_a, mem_write, mem_size, mem_sel, mem_st_data};
        ok = mem_access && (i_ready ^ d_ready) && (k < 20);
        tick();
        mem_ready = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #4;
        n_checks++; if (mem_access !== 1'b0) begin n_fail++; $display("FAIL reset_access: got %b want 0", mem_access); end
        n_checks++; if ({i_ready, d_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {i_ready, d_ready}); end
        n_checks++; if ({mem_a, mem_write, mem_size, mem_sel, mem_st_data} !== 71'h0) begin n_fail++; $display("FAIL reset_latch: got %h want 0", {mem_a, mem_write, mem_size, mem_sel, mem_st_data}); end
        n_checks++; if ({cnt_i_grant, cnt_d_grant, cnt_conflict} !== 96'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", {cnt_i_grant, cnt_d_grant, cnt_conflict}); end
    endtask

    task automatic test_lone_d_read();
        txn_t exp, got;
        do_reset();
        d_strobe = 1; d_addr = 32'h1FC0_0100; d_write = 0; d_size = 2'b10; d_sel = 4'hF; d_wdata = 32'h1234_5678;
        sb.push_back(mk_d(32'h1FC0_0100, 1'b0, 2'b10, 4'hF, 32'h1234_5678));
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) mem_ready = 1;
            #4;
            n_checks++; if (mem_access !== 1'b1 || mem_a !== 32'h1FC0_0100) begin n_fail++; $display("FAIL lone_busy c%0d: got access=%b a=%h want 1 1fc00100", c, mem_access, mem_a); end
            n_checks++; if (d_ready !== (c == 5) || i_ready !== 1'b0) begin n_fail++; $display("FAIL lone_ready c%0d: got d=%b i=%b want d=%b i=0", c, d_ready, i_ready, c == 5); end
            if (c == 5) begin
                got = {d_ready, mem_a, mem_write, mem_size, mem_sel, mem_st_data};
                exp = sb.pop_front();
                n_checks++; if (got !== exp) begin n_fail++; $display("FAIL lone_txn: got %h want %h", got, exp); end
            end
        end
        tick();
        mem_ready = 0; d_strobe = 0;
        #4;
        n_checks++; if (mem_access !== 1'b0 || d_ready !== 1'b0) begin n_fail++; $display("FAIL lone_idle: got access=%b d=%b want 0 0", mem_access, d_ready); end
        n_checks++; if (cnt_d_grant !== 32'd1 || cnt_i_grant !== 32'd0) begin n_fail++; $display("FAIL lone_cnt: got d=%0d i=%0d want 1 0", cnt_d_grant, cnt_i_grant); end
    endtask

    task automatic test_simultaneous();
        txn_t exp, got;
        logic ok;
        do_reset();
        i_addr = 32'h0000_2000; i_strobe = 1;
        d_addr = 32'h0000_3000; d_write = 1; d_size = 2'b01; d_sel = 4'b0011; d_wdata = 32'hCAFE_BABE; d_strobe = 1;
        sb.push_back(mk_i(32'h0000_2000));
        sb.push_back(mk_d(32'h0000_3000, 1'b1, 2'b01, 4'b0011, 32'hCAFE_BABE));
        serve(2, got, ok);
        i_strobe = 0;
        exp = sb.pop_front();
        n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL simul_first: got %h ok=%b want %h", got, ok, exp); end
        #4;
        n_checks++; if (mem_access !== 1'b1 || mem_a !== 32'h0000_3000 || mem_write !== 1'b1) begin n_fail++; $display("FAIL simul_handoff: got access=%b a=%h w=%b want 1 00003000 1", mem_access, mem_a, mem_write); end
        n_checks++; if (cnt_conflict !== 32'd1) begin n_fail++; $display("FAIL simul_conflict: got %0d want 1", cnt_conflict); end
        tick();
        serve(1, got, ok);
        d_strobe = 0;
        exp = sb.pop_front();
        n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL simul_second: got %h ok=%b want %h", got, ok, exp); end
        #4;
        n_checks++; if ({cnt_i_grant, cnt_d_grant, cnt_conflict} !== {32'd1, 32'd1, 32'd1}) begin n_fail++; $display("FAIL simul_cnt: got i=%0d d=%0d c=%0d want 1 1 1", cnt_i_grant, cnt_d_grant, cnt_conflict); end
    endtask

    task automatic test_round_robin();
        txn_t exp, got;
        logic ok;
        do_reset();
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_write = 0; d_size = 2'b10; d_sel = 4'hF; d_wdata = 32'h0;
        for (int k = 0; k < 10; k++) sb.push_back((k % 2 == 0) ? mk_i(32'h0000_0100) : mk_d(32'h0000_0200, 1'b0, 2'b10, 4'hF, 32'h0));
        i_strobe = 1; d_strobe = 1;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) i_strobe = 0;
            serve(k % 3, got, ok);
            exp = sb.pop_front();
            n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL rr_txn%0d: got %h ok=%b want %h", k, got, ok, exp); end
        end
        d_strobe = 0;
        #4;
        n_checks++; if (mem_access !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", mem_access); end
        n_checks++; if ({cnt_i_grant, cnt_d_grant, cnt_conflict} !== {32'd5, 32'd5, 32'd1}) begin n_fail++; $display("FAIL rr_cnt: got i=%0d d=%0d c=%0d want 5 5 1", cnt_i_grant, cnt_d_grant, cnt_conflict); end
    endtask

    task automatic test_latch_stability();
        txn_t exp, got;
        logic ok;
        do_reset();
        d_strobe = 1; d_addr = 32'hA000_0040; d_write = 1; d_size = 2'b01; d_sel = 4'b0011; d_wdata = 32'h5A5A_1234;
        sb.push_back(mk_d(32'hA000_0040, 1'b1, 2'b01, 4'b0011, 32'h5A5A_1234));
        for (int c = 1; c <= 4; c++) begin
            tick();
            d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);
            #4;
            n_checks++; if (mem_a !== 32'hA000_0040 || mem_st_data !== 32'h5A5A_1234 || mem_sel !== 4'b0011) begin n_fail++; $display("FAIL latch_hold c%0d: got a=%h wd=%h sel=%b want a0000040 5a5a1234 0011", c, mem_a, mem_st_data, mem_sel); end
        end
        tick();
        serve(0, got, ok);
        d_strobe = 0;
        exp = sb.pop_front();
        n_checks++; if (!ok || got !== exp) begin n_fail++; $display("FAIL latch_txn: got %h ok=%b want %h", got, ok, exp); end
    endtask

    task automatic test_abandoned();
        txn_t exp, got;
        do_reset();
        i_strobe = 1; i_addr = 32'h0040_0008;
        sb.push_back(mk_i(32'h0040_0008));
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 3) i_strobe = 0;
            if (c == 5) mem_ready = 1;
            #4;
            n_checks++; if (mem_access !== 1'b1) begin n_fail++; $display("FAIL aband_access c%0d: got %b want 1", c, mem_access); end
            if (c == 5) begin
                got = {d_ready, mem_a, mem_write, mem_size, mem_sel, mem_st_data};
                exp = sb.pop_front();
                n_checks++; if (i_ready !== 1'b1 || got !== exp) begin n_fail++; $display("FAIL aband_txn: got %h i_ready=%b want %h 1", got, i_ready, exp); end
            end
        end
        tick();
        mem_ready = 0;
        #4;
        n_checks++; if (mem_access !== 1'b0 || i_ready !== 1'b0) begin n_fail++; $display("FAIL aband_idle: got access=%b i=%b want 0 0", mem_access, i_ready); end
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        tick();
        mem_ready = 1;
        #4;
        n_checks++; if ({i_ready, d_ready, mem_access} !== 3'b000) begin n_fail++; $display("FAIL spurious: got %b want 000", {i_ready, d_ready, mem_access}); end
        tick();
        mem_ready = 0; d_strobe = 1; d_addr = 32'h0000_0BAD; d_wdata = 32'h1;
        tick(); tick();
        #4;
        n_checks++; if (mem_access !== 1'b1 || cnt_d_grant !== 32'd1) begin n_fail++; $display("FAIL rst_busy: got access=%b d=%0d want 1 1", mem_access, cnt_d_grant); end
        tick();
        rst = 1;
        tick();
        #4;
        n_checks++; if (mem_access !== 1'b0 || mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_mid_access: got access=%b a=%h want 0 0", mem_access, mem_a); end
        n_checks++; if ({cnt_i_grant, cnt_d_grant, cnt_conflict} !== 96'h0) begin n_fail++; $display("FAIL rst_mid_cnt: got %h want 0", {cnt_i_grant, cnt_d_grant, cnt_conflict}); end
        rst = 0; d_strobe = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_d_read();
        test_simultaneous();
        test_round_robin();
        test_latch_stability();
        test_abandoned();
        test_spurious_and_reset();
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
